// File: rtl/conv1d_job_sched_if.sv
// Bundle of the submit, accelerator and completion signals of conv1d_job_sched.
// slave is the scheduler's view; master is the submitter/accelerator/core side.
interface conv1d_job_sched_if #(
    parameter int AddrWidth = 32,
    parameter int LenWidth  = 16,
    parameter int IdWidth   = 4,
    parameter int Depth     = 4
);
    logic                   sub_valid_i;
    logic                   sub_ready_o;
    logic [AddrWidth-1:0]   sub_src_i;
    logic [AddrWidth-1:0]   sub_dst_i;
    logic [LenWidth-1:0]    sub_len_i;
    logic [IdWidth-1:0]     sub_id_i;
    logic                   flush_i;

    logic                   acc_cfg_valid_o;
    logic                   acc_cfg_ready_i;
    logic [AddrWidth-1:0]   acc_src_o;
    logic [AddrWidth-1:0]   acc_dst_o;
    logic [LenWidth-1:0]    acc_len_o;
    logic                   acc_start_o;
    logic                   acc_done_i;
    logic                   acc_abort_o;

    logic                   cpl_valid_o;
    logic [IdWidth-1:0]     cpl_id_o;
    logic                   cpl_err_o;
    logic                   irq_o;
    logic                   irq_clr_i;
    logic [$clog2(Depth):0] fill_o;
    logic                   busy_o;

    modport slave (
        input  sub_valid_i, sub_src_i, sub_dst_i, sub_len_i, sub_id_i, flush_i,
        input  acc_cfg_ready_i, acc_done_i, irq_clr_i,
        output sub_ready_o, acc_cfg_valid_o, acc_src_o, acc_dst_o, acc_len_o,
        output acc_start_o, acc_abort_o, cpl_valid_o, cpl_id_o, cpl_err_o,
        output irq_o, fill_o, busy_o
    );

    modport master (
        output sub_valid_i, sub_src_i, sub_dst_i, sub_len_i, sub_id_i, flush_i,
        output acc_cfg_ready_i, acc_done_i, irq_clr_i,
        input  sub_ready_o, acc_cfg_valid_o, acc_src_o, acc_dst_o, acc_len_o,
        input  acc_start_o, acc_abort_o, cpl_valid_o, cpl_id_o, cpl_err_o,
        input  irq_o, fill_o, busy_o
    );
endinterface

// File: rtl/conv1d_job_sched.sv
// Queues conv1d descriptors and runs them one at a time on the accelerator.
// Optional BUSY watchdog: define CONV1D_JOB_SCHED_TIMEOUT_EN.
module conv1d_job_sched #(
    parameter int AddrWidth     = 32,
    parameter int LenWidth      = 16,
    parameter int IdWidth       = 4,
    parameter int Depth         = 4,
    parameter int TimeoutCycles = 65535
) (
    input logic               clk_i,
    input logic               rst_i,
    conv1d_job_sched_if.slave bus
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    typedef struct packed {
        logic [AddrWidth-1:0] src;
        logic [AddrWidth-1:0] dst;
        logic [LenWidth-1:0]  len;
        logic [IdWidth-1:0]   id;
    } desc_t;

    typedef enum logic [2:0] {S_IDLE, S_CFG, S_START, S_BUSY, S_DONE} state_e;

    desc_t                fifo_mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    state_e               state_q, state_d;
    logic [AddrWidth-1:0] src_q, src_d;
    logic [AddrWidth-1:0] dst_q, dst_d;
    logic [LenWidth-1:0]  len_q, len_d;
    logic [IdWidth-1:0]   id_q, id_d;
    logic                 err_q, err_d;
    logic                 irq_q, irq_d;

    logic  sub_ready;
    logic  push;
    logic  pop;
    logic  cfg_valid;
    logic  start;
    logic  cpl;
    logic  abort;
    desc_t head;
    desc_t sub_desc;

    assign sub_ready = (count_q < CntW'(Depth));
    assign push      = bus.sub_valid_i && sub_ready && !bus.flush_i;
    assign head      = fifo_mem_q[rd_ptr_q];
    assign sub_desc  = '{src: bus.sub_src_i, dst: bus.sub_dst_i,
                         len: bus.sub_len_i, id: bus.sub_id_i};

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= sub_desc;
        end
    end

`ifdef CONV1D_JOB_SCHED_TIMEOUT_EN
    localparam int TmoW = $clog2(TimeoutCycles + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            tmo_hit;

    assign tmo_hit = (tmo_q == TmoW'(TimeoutCycles));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        id_d      = id_q;
        err_d     = err_q;
        pop       = 1'b0;
        cfg_valid = 1'b0;
        start     = 1'b0;
        cpl       = 1'b0;
`ifdef CONV1D_JOB_SCHED_TIMEOUT_EN
        tmo_d     = tmo_q;
        abort     = 1'b0;
`else
        // Constant 0; the comparison only keeps the limit parameter referenced.
        abort     = (TimeoutCycles < 0);
`endif

        unique case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && !bus.flush_i) begin
                    pop  = 1'b1;
                    id_d = head.id;
                    // Zero-length jobs complete immediately and leave the
                    // accelerator-facing fields at their previous values.
                    if (head.len == '0) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        src_d   = head.src;
                        dst_d   = head.dst;
                        len_d   = head.len;
                        err_d   = 1'b0;
                        state_d = S_CFG;
                    end
                end
            end
            S_CFG: begin
                cfg_valid = 1'b1;
                if (bus.acc_cfg_ready_i) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                start   = 1'b1;
                state_d = S_BUSY;
`ifdef CONV1D_JOB_SCHED_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_BUSY: begin
                if (bus.acc_done_i) begin
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end
`ifdef CONV1D_JOB_SCHED_TIMEOUT_EN
                else if (tmo_hit) begin
                    abort   = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                cpl     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        irq_d    = irq_q;

        if (bus.flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end

        if (bus.irq_clr_i) begin
            irq_d = 1'b0;
        end
        if (state_q == S_DONE) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            id_q     <= '0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            id_q     <= id_d;
            err_q    <= err_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.sub_ready_o     = sub_ready;
    assign bus.acc_cfg_valid_o = cfg_valid;
    assign bus.acc_src_o       = src_q;
    assign bus.acc_dst_o       = dst_q;
    assign bus.acc_len_o       = len_q;
    assign bus.acc_start_o     = start;
    assign bus.acc_abort_o     = abort;
    assign bus.cpl_valid_o     = cpl;
    assign bus.cpl_id_o        = id_q;
    assign bus.cpl_err_o       = err_q;
    assign bus.irq_o           = irq_q;
    assign bus.fill_o          = count_q;
    assign bus.busy_o          = (state_q != S_IDLE);

endmodule
